// File: rtl/fifo_rr_drain_sched.sv
// Round-robin drain scheduler: reads a bank of sync FIFOs one word at a time and
// forwards each word on a shared valid/ready port tagged with its queue id.
module fifo_rr_drain_sched #(
  parameter int NUM_Q      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST      = 4
) (
  input  logic                          clk,
  input  logic                          aclr_n,
  input  logic                          sclr_n,
  input  logic [NUM_Q-1:0]              q_empty,
  input  logic [NUM_Q*DATA_WIDTH-1:0]   q_dout,
  output logic [NUM_Q-1:0]              q_rd_en,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic [$clog2(NUM_Q)-1:0]      m_qid,
  output logic                          m_last,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          busy
);

  localparam int QW = $clog2(NUM_Q);
  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);
  localparam logic [QW-1:0] Q_LAST   = QW'(NUM_Q - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, HOLD} state_t;

  state_t                state;
  logic [QW-1:0]         grant;
  logic [QW-1:0]         ptr;
  logic [CW-1:0]         cnt;
  logic                  found;
  logic [QW-1:0]         pick;
  logic [QW-1:0]         idx;
  logic [QW-1:0]         grant_next;
  logic [DATA_WIDTH-1:0] dout_arr [NUM_Q];

  always_comb begin
    for (int unsigned i = 0; i < NUM_Q; i++) begin
      dout_arr[i] = q_dout[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // First non-empty queue at or after ptr, wrapping at NUM_Q-1.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_Q; i++) begin
      idx = QW'((32'(ptr) + i) % NUM_Q);
      if (!found && !q_empty[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign grant_next = (grant == Q_LAST) ? '0 : grant + 1'b1;
  assign busy       = (state != IDLE);

  // Strobe is gated by sclr_n so a clear landing in ISSUE never pops a word.
  always_comb begin
    q_rd_en = '0;
    if (state == ISSUE && sclr_n && !q_empty[grant]) begin
      q_rd_en[grant] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state   <= IDLE;
      grant   <= '0;
      ptr     <= '0;
      cnt     <= '0;
      m_data  <= '0;
      m_qid   <= '0;
      m_last  <= 1'b0;
      m_valid <= 1'b0;
    end else if (!sclr_n) begin
      state   <= IDLE;
      grant   <= '0;
      ptr     <= '0;
      cnt     <= '0;
      m_data  <= '0;
      m_qid   <= '0;
      m_last  <= 1'b0;
      m_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant <= pick;
            cnt   <= '0;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (!q_empty[grant]) begin
            state <= CAPTURE;
          end else begin
            ptr   <= grant_next;
            state <= IDLE;
          end
        end
        CAPTURE: begin
          m_data  <= dout_arr[grant];
          m_qid   <= grant;
          m_valid <= 1'b1;
          m_last  <= (cnt == CNT_LAST) || q_empty[grant];
          state   <= HOLD;
        end
        HOLD: begin
          if (m_valid && m_ready) begin
            m_valid <= 1'b0;
            if (m_last) begin
              ptr    <= grant_next;
              m_last <= 1'b0;
              state  <= IDLE;
            end else begin
              cnt   <= cnt + 1'b1;
              state <= ISSUE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rr_drain_sched.sv
// Bench for fifo_rr_drain_sched: behavioural FIFO bank, round-robin reference
// model producing the expected word stream, and a scoreboard monitor.
module tb_fifo_rr_drain_sched;

  localparam int NQ = 4;
  localparam int DW = 8;
  localparam int BR = 4;
  localparam int QW = $clog2(NQ);

  typedef logic [DW-1:0] word_t;
  typedef struct {
    word_t data;
    int    qid;
    bit    last;
  } exp_t;

  logic              clk = 1'b0;
  logic              aclr_n = 1'b1;
  logic              sclr_n = 1'b1;
  logic [NQ-1:0]     q_empty = '1;
  logic [NQ*DW-1:0]  q_dout = '0;
  logic [NQ-1:0]     q_rd_en;
  logic [DW-1:0]     m_data;
  logic [QW-1:0]     m_qid;
  logic              m_last;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic              busy;

  int    errors = 0;
  int    checks = 0;
  int    ready_mode = 0;   // 0: always ready, 1: random, 2: stalled
  int    model_ptr = 0;
  word_t fifo [NQ][$];
  word_t pend [NQ][$];
  exp_t  exp_q [$];

  fifo_rr_drain_sched #(
    .NUM_Q(NQ),
    .DATA_WIDTH(DW),
    .BURST(BR)
  ) dut (
    .clk(clk),
    .aclr_n(aclr_n),
    .sclr_n(sclr_n),
    .q_empty(q_empty),
    .q_dout(q_dout),
    .q_rd_en(q_rd_en),
    .m_data(m_data),
    .m_qid(m_qid),
    .m_last(m_last),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic int fifo_total();
    int t = 0;
    for (int i = 0; i < NQ; i++) t += fifo[i].size() + pend[i].size();
    return t;
  endfunction

  // Reference: whole-drain word order from current contents, grants rotate from
  // model_ptr, each grant takes min(BURST, remaining) words.
  function automatic void build_expected();
    word_t work [NQ][$];
    int    g;
    int    n;
    exp_t  e;
    exp_q.delete();
    for (int i = 0; i < NQ; i++) begin
      work[i] = fifo[i];
      foreach (pend[i][k]) work[i].push_back(pend[i][k]);
    end
    forever begin
      g = -1;
      for (int k = 0; k < NQ; k++) begin
        if (g < 0 && work[(model_ptr + k) % NQ].size() > 0) g = (model_ptr + k) % NQ;
      end
      if (g < 0) break;
      n = 0;
      while (n < BR && work[g].size() > 0) begin
        e.data = work[g].pop_front();
        n++;
        e.qid  = g;
        e.last = (n == BR) || (work[g].size() == 0);
        exp_q.push_back(e);
      end
      model_ptr = (g + 1) % NQ;
    end
  endfunction

  // Sync FIFO bank: registered dout, flags updated at the edge.
  always @(posedge clk) begin
    for (int i = 0; i < NQ; i++) begin
      if (q_rd_en[i]) begin
        checks++;
        if (fifo[i].size() == 0) begin
          errors++;
          $display("FAIL underflow q%0d: read strobe on empty FIFO at %0t", i, $time);
        end else begin
          q_dout[i*DW +: DW] <= fifo[i].pop_front();
        end
      end
      while (pend[i].size() > 0) fifo[i].push_back(pend[i].pop_front());
      q_empty[i] <= (fifo[i].size() == 0);
    end
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ($urandom_range(0, 3) != 0);
      default: m_ready = 1'b0;
    endcase
  end

  logic          held = 1'b0;
  logic [DW-1:0] h_data;
  logic [QW-1:0] h_qid;
  logic          h_last;

  always @(negedge clk) begin
    if (!aclr_n || !sclr_n) begin
      held = 1'b0;
    end else begin
      check("rd_onehot", 64'($onehot0(q_rd_en)), 64'd1);
      if (m_valid) check("rd_while_valid", 64'(q_rd_en), 64'd0);
      if (held) check("hold_stable", {m_valid, m_last, m_qid, m_data}, {1'b1, h_last, h_qid, h_data});
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word: got q%0d data %0h expected none", m_qid, m_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("word", {m_data, 8'(m_qid), 7'd0, m_last}, {e.data, 8'(e.qid), 7'd0, e.last});
        end
      end
      held   = m_valid && !m_ready;
      h_data = m_data;
      h_qid  = m_qid;
      h_last = m_last;
    end
  end

  task automatic load(input int c [NQ]);
    @(posedge clk);
    #1;
    for (int i = 0; i < NQ; i++) begin
      for (int k = 0; k < c[i]; k++) pend[i].push_back(word_t'($urandom));
    end
    build_expected();
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy || fifo_total() != 0) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_words_left"}, 64'(exp_q.size()), 64'd0);
    check({name, "_fifo_left"}, 64'(fifo_total()), 64'd0);
    check({name, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!m_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_valid_seen"}, 64'(m_valid), 64'd1);
  endtask

  initial begin
    int c [NQ];
    int n;
    #2 aclr_n = 1'b0;
    #1 check("reset_outputs", {q_rd_en, m_valid, m_data, m_qid, m_last, busy}, '0);
    repeat (2) @(posedge clk);
    #1 aclr_n = 1'b1;

    // Single queue, two words.
    ready_mode = 0;
    c = '{0, 2, 0, 0};
    load(c);
    drain("q1_only");

    // Five words everywhere: full bursts then singles.
    c = '{5, 5, 5, 5};
    load(c);
    drain("five_each");

    // Grant of q2 leaves ptr at 3; q3 must then precede q0.
    c = '{0, 0, 3, 0};
    load(c);
    drain("q2_only");
    c = '{2, 0, 0, 2};
    load(c);
    drain("wrap");

    for (int e = 0; e < 8; e++) begin
      ready_mode = 1;
      for (int i = 0; i < NQ; i++) c[i] = $urandom_range(0, 9);
      load(c);
      drain("random");
    end

    // Ten-cycle stall while a word is held.
    ready_mode = 2;
    c = '{2, 1, 0, 3};
    load(c);
    wait_valid("stall");
    repeat (10) @(posedge clk);
    @(negedge clk);
    ready_mode = 0;
    @(posedge clk);
    @(posedge clk);
    #1 check("stall_release", 64'(m_valid), 64'd0);
    drain("stall");

    // Async clear while a word waits in HOLD.
    ready_mode = 2;
    c = '{3, 3, 3, 3};
    load(c);
    wait_valid("aclr");
    @(posedge clk);
    #1 aclr_n = 1'b0;
    #1 check("aclr_outputs", {q_rd_en, m_valid, m_data, m_qid, m_last, busy}, '0);
    exp_q.delete();
    model_ptr = 0;
    build_expected();
    ready_mode = 0;
    @(posedge clk);
    #1 aclr_n = 1'b1;
    drain("after_aclr");

    // Sync clear during the read-strobe cycle.
    ready_mode = 0;
    c = '{3, 3, 3, 3};
    load(c);
    n = 0;
    while (q_rd_en == '0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("sclr_issue_seen", 64'(q_rd_en != '0), 64'd1);
    sclr_n = 1'b0;
    #1 check("sclr_rd_gated", 64'(q_rd_en), 64'd0);
    exp_q.delete();
    model_ptr = 0;
    build_expected();
    @(posedge clk);
    #1 check("sclr_outputs", {q_rd_en, m_valid, m_data, m_qid, m_last, busy}, '0);
    sclr_n = 1'b1;
    drain("after_sclr");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_rr_drain_sched.md
# fifo_rr_drain_sched

Round-robin drain scheduler that shares one downstream valid/ready port among NUM_Q sync FIFOs. It watches each FIFO's empty flag, issues single-cycle read strobes, and captures the registered FIFO output. It forwards each word downstream tagged with its queue ID, granting each queue up to BURST consecutive words before it rotates. It sits between a bank of sync FIFOs and a shared consumer such as a serializer or bus master.

## Interface

- NUM_Q, 4, number of FIFOs served; must be ≥ 2.
- DATA_WIDTH, 8, FIFO word width.
- BURST, 4, maximum words per grant; must be ≥ 1.

- clk  input  1  rising-edge clock, shared with the FIFOs.
- aclr_n  input  1  asynchronous active-low reset.
- sclr_n  input  1  synchronous active-low clear; same effect as aclr_n, applied at the clock edge.
- q_empty  input  NUM_Q  empty flag of each FIFO; bit i belongs to queue i.
- q_dout  input  NUM_Q*DATA_WIDTH  FIFO dout buses; queue i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- q_rd_en  output  NUM_Q  read strobes; at most one bit is high at a time.
- m_data  output  DATA_WIDTH  output word.
- m_qid  output  $clog2(NUM_Q)  source queue of m_data.
- m_last  output  1  marks the final word of the current grant.
- m_valid  output  1  output word valid.
- m_ready  input  1  downstream accept.
- busy  output  1  high whenever the state is not IDLE.

## Operation

- Registers:
  - state ∈ {IDLE, ISSUE, CAPTURE, HOLD}.
  - grant, $clog2(NUM_Q) bits.
  - ptr, $clog2(NUM_Q) bits: the next queue with priority.
  - cnt, max(1,$clog2(BURST)) bits: words delivered in the current grant.
- IDLE:
  - If no queue is non-empty, stay in IDLE.
  - Otherwise set grant to the first non-empty queue scanning ptr, ptr+1, …, wrapping from NUM_Q-1 to 0.
  - Set cnt=0 and go to ISSUE.
- ISSUE:
  - q_rd_en[grant] = !q_empty[grant]. This is combinational and low in every other state.
  - If q_empty[grant]=0, go to CAPTURE.
  - Otherwise (defensive case), set ptr=grant+1 mod NUM_Q and go to IDLE.
- CAPTURE:
  - The FIFO dout is valid in this cycle.
  - Register m_data ← q_dout[grant] and m_qid ← grant, set m_valid ← 1.
  - Register m_last ← (cnt==BURST-1) || q_empty[grant]. q_empty here is already the post-read flag.
  - Go to HOLD.
- HOLD:
  - m_data, m_qid and m_last stay stable while m_valid && !m_ready.
  - On m_valid && m_ready, clear m_valid.
  - If m_last: set ptr=grant+1 mod NUM_Q, clear m_last, go to IDLE.
  - Otherwise: cnt=cnt+1, go to ISSUE.
- A grant ends on whichever comes first: BURST words delivered, or the queue draining.
- A queue never receives two consecutive grants while another queue is non-empty.
- Never strobe q_rd_en while a captured word is undelivered; this guarantees no FIFO underflow and no lost data.

## Timing

- Reset values (aclr_n immediately, sclr_n at the next edge):
  - state=IDLE, ptr=0, grant=0, cnt=0.
  - q_rd_en=0, m_valid=0, m_data=0, m_qid=0, m_last=0, busy=0.
- Reset in any state abandons the operation. A word already read from a FIFO but not delivered is discarded; this is accepted behaviour.
- Latency:
  - IDLE sees non-empty at cycle T.
  - q_rd_en is high in cycle T+1.
  - m_valid rises at the edge ending T+2.
- Throughput is one word per 3 cycles with m_ready held high, plus 1 IDLE cycle between grants.
- The scheduler samples q_empty, so it may see a FIFO write that lands in the same cycle a cycle late. This is harmless: the scheduler only reads when empty=0.

## Test plan

- Only q1 holds A,B; BURST=4; m_ready=1 → q_rd_en=4'b0010 for exactly one cycle, twice. Output A (qid=1, last=0), then B (qid=1, last=1). busy drops and q1 is never read again.
- Each queue holds 5 words, BURST=4, m_ready=1 → qid sequence 0×4, 1×4, 2×4, 3×4, 0, 1, 2, 3. m_last is high on every 4th word of the first round and on each single word of the second round. 20 words total, no duplicates.
- m_ready held low for 10 cycles while m_valid=1 → m_data, m_qid and m_last are constant and q_rd_en=0 throughout. The transfer completes on the first cycle m_ready=1.
- Wrap-around: a grant of q2 ends, leaving ptr=3, with only q0 and q3 non-empty → the next grant is q3, then q0.
- aclr_n pulsed low mid-HOLD → all outputs are reset values immediately. After release, with all queues non-empty, the first grant is q0.
- sclr_n low for one cycle during ISSUE → outputs reach reset values at that edge. q_rd_en is gated off in the clear cycle. The first grant after the clear is q0.
